// File: rtl/segment_display_n.sv
// segment_display_n
// -----------------
// Multiplexed driver for a bank of DIGITS seven-segment digits.
//
// The scan position is a free-running pair of counters (digit index and a
// dwell count within the digit's time slot). At the start of every frame the
// display inputs are captured into a snapshot, so a change on the inputs
// never tears a frame. The outputs are registered from the delayed scan
// position, the snapshot and a free-running blink phase.
//
// Input to output latency is two clock edges. The first edge after reset
// release loads the snapshot. The second edge drives digit 0.
//
// Ports:
//   clk_1kHz     scan clock; all state changes on its rising edge
//   rst          asynchronous active-high reset (outputs blank at once)
//   en           per-digit enable, 1 = digit may light
//   bin          hex nibbles, digit i = bin[4i+3:4i], digit 0 least significant
//   dpin         per-digit decimal point request
//   blink        per-digit blink request (digit is dark during blink phase 1)
//   lzb          leading-zero blanking enable
//   bright       brightness level: lit cycles per slot = bright + 1
//   an           digit select, active-low, at most one bit low
//   seg          {dp,g,f,e,d,c,b,a}, active-low
//   frame_start  one-cycle pulse on the first output cycle of digit 0
module segment_display_n #(
  parameter int DIGITS     = 4,
  parameter int DWELL      = 4,
  parameter int BRIGHT_W   = 2,
  parameter int BLINK_HALF = 250
) (
  input  logic                  clk_1kHz,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     en,
  input  logic [4*DIGITS-1:0]   bin,
  input  logic [DIGITS-1:0]     dpin,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lzb,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  frame_start
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int DW_W  = $clog2(DWELL);
  localparam int BC_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  // Stage 0: scan counters
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;

  // Blink timer, independent of the scan
  logic [BC_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;

  // Stage 1: delayed scan position and frame snapshot
  logic [IDX_W-1:0]    idx_p_q;
  logic [DW_W-1:0]     dwell_p_q;
  // Marks that stage 1 holds a real scan position. Without it the reset
  // values of the delayed position would look like digit 0, slot 0 and fire
  // a frame_start one edge early.
  logic                valid_q;
  logic [DIGITS-1:0]   en_s_q;
  logic [4*DIGITS-1:0] bin_s_q;
  logic [DIGITS-1:0]   dpin_s_q;
  logic [DIGITS-1:0]   blink_s_q;
  logic                lzb_s_q;
  logic [BRIGHT_W-1:0] bright_s_q;

  // Stage 2: registered outputs
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]        seg_q, seg_d;
  logic              fs_q, fs_d;

  logic frame_edge;
  assign frame_edge = (idx_q == '0) && (dwell_q == '0);

  // Hex to gfedcba, active-high
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Counter next-state
  always_comb begin
    dwell_d       = dwell_q + 1'b1;
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (dwell_q == DW_W'(DWELL - 1)) begin
      dwell_d = '0;
      if (idx_q == IDX_W'(DIGITS - 1)) idx_d = '0;
      else                             idx_d = idx_q + 1'b1;
    end
    if (blink_cnt_q == BC_W'(BLINK_HALF - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_ff @(posedge clk_1kHz or posedge rst) begin
    if (rst) begin
      idx_q         <= '0;
      dwell_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      dwell_q       <= dwell_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Stage 1
  always_ff @(posedge clk_1kHz or posedge rst) begin
    if (rst) begin
      idx_p_q    <= '0;
      dwell_p_q  <= '0;
      valid_q    <= 1'b0;
      en_s_q     <= '0;
      bin_s_q    <= '0;
      dpin_s_q   <= '0;
      blink_s_q  <= '0;
      lzb_s_q    <= 1'b0;
      bright_s_q <= '0;
    end else begin
      idx_p_q   <= idx_q;
      dwell_p_q <= dwell_q;
      valid_q   <= 1'b1;
      if (frame_edge) begin
        en_s_q     <= en;
        bin_s_q    <= bin;
        dpin_s_q   <= dpin;
        blink_s_q  <= blink;
        lzb_s_q    <= lzb;
        bright_s_q <= bright;
      end
    end
  end

  // Stage 2 decode
  logic [3:0] nib;
  logic       en_k, dp_k, blink_k, upper_zero, lead_zero, hard_off;

  always_comb begin
    an_d       = '1;
    seg_d      = 8'hFF;
    nib        = 4'h0;
    en_k       = 1'b0;
    dp_k       = 1'b0;
    blink_k    = 1'b0;
    upper_zero = 1'b1;
    fs_d       = valid_q && (idx_p_q == '0) && (dwell_p_q == '0);

    for (int j = 0; j < DIGITS; j++) begin
      if (idx_p_q == IDX_W'(j)) begin
        nib     = bin_s_q[4*j +: 4];
        en_k    = en_s_q[j];
        dp_k    = dpin_s_q[j];
        blink_k = blink_s_q[j];
      end
      // Leading zero means this digit and every more significant one is 0
      if ((IDX_W'(j) >= idx_p_q) && (bin_s_q[4*j +: 4] != 4'h0))
        upper_zero = 1'b0;
    end

    lead_zero = lzb_s_q && (idx_p_q != '0) && upper_zero;
    // PWM: the slot is lit only for dwell positions 0..bright
    hard_off  = !en_k || (blink_k && blink_phase_q) ||
                (dwell_p_q > DW_W'(bright_s_q));

    for (int j = 0; j < DIGITS; j++) begin
      if (valid_q && !hard_off && (idx_p_q == IDX_W'(j))) begin
        if (lead_zero) begin
          if (dp_k) begin
            an_d[j] = 1'b0;
            seg_d   = 8'b0111_1111;
          end
        end else begin
          an_d[j] = 1'b0;
          seg_d   = ~{dp_k, hex7(nib)};
        end
      end
    end
  end

  always_ff @(posedge clk_1kHz or posedge rst) begin
    if (rst) begin
      an_q  <= '1;
      seg_q <= 8'hFF;
      fs_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      fs_q  <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_segment_display_n.sv
module tb_segment_display_n;

  localparam int DG    = 4;
  localparam int DW    = 4;
  localparam int BW    = 2;
  localparam int BH    = 8;
  localparam int FRAME = DG * DW;

  // Clock / reset
  logic clk_1kHz = 1'b0;
  logic rst;
  always #5 clk_1kHz = ~clk_1kHz;

  logic [DG-1:0]   en, dpin, blink;
  logic [4*DG-1:0] bin;
  logic            lzb;
  logic [BW-1:0]   bright;
  logic [DG-1:0]   an;
  logic [7:0]      seg;
  logic            frame_start;

  segment_display_n #(
    .DIGITS(DG), .DWELL(DW), .BRIGHT_W(BW), .BLINK_HALF(BH)
  ) dut (
    .clk_1kHz(clk_1kHz), .rst(rst), .en(en), .bin(bin), .dpin(dpin),
    .blink(blink), .lzb(lzb), .bright(bright), .an(an), .seg(seg),
    .frame_start(frame_start)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state: edges since reset release and the frame snapshot
  int              t;
  logic [DG-1:0]   s_en, s_dp, s_blink;
  logic [4*DG-1:0] s_bin;
  logic            s_lzb;
  logic [BW-1:0]   s_bright;
  logic [6:0]      hex_tab[16];
  logic [DG-1:0]   exp_an;
  logic [7:0]      exp_seg;
  logic            exp_fs;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_clear();
    t        = 0;
    s_en     = '0;
    s_dp     = '0;
    s_blink  = '0;
    s_bin    = '0;
    s_lzb    = 1'b0;
    s_bright = '0;
  endtask

  // Expected outputs after edge t, derived from the frame timeline:
  // edge t shows scan position p = t-2, and the blink phase reflects the
  // t-1 timer ticks that preceded the edge.
  task automatic model_edge();
    int   p, k, d;
    logic phase, off, lz;
    t++;
    exp_an  = '1;
    exp_seg = 8'hFF;
    exp_fs  = 1'b0;
    if (t >= 2) begin
      p      = t - 2;
      k      = (p / DW) % DG;
      d      = p % DW;
      phase  = (((t - 1) / BH) % 2) == 1;
      exp_fs = (p % FRAME) == 0;
      off    = !s_en[k] || (s_blink[k] && phase) || (d > int'(s_bright));
      lz     = s_lzb && (k != 0) && ((s_bin >> (4 * k)) == '0);
      if (!off) begin
        if (lz) begin
          if (s_dp[k]) begin
            exp_an[k] = 1'b0;
            exp_seg   = 8'h7F;
          end
        end else begin
          exp_an[k] = 1'b0;
          exp_seg   = ~{s_dp[k], hex_tab[s_bin[4*k +: 4]]};
        end
      end
    end
    // A new frame's snapshot is taken on edges 1, 1+FRAME, 1+2*FRAME...
    if (((t - 1) % FRAME) == 0) begin
      s_en     = en;
      s_dp     = dpin;
      s_blink  = blink;
      s_bin    = bin;
      s_lzb    = lzb;
      s_bright = bright;
    end
  endtask

  // Driver: advance one edge, update the model, sample 1 time unit later
  task automatic step();
    @(posedge clk_1kHz);
    model_edge();
    #1;
    check("an", {4'h0, an}, {4'h0, exp_an});
    check("seg", seg, exp_seg);
    check("frame_start", {7'h0, frame_start}, {7'h0, exp_fs});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic expect_out(input string tag, input logic [DG-1:0] a, input logic [7:0] s);
    check({tag, "_an"}, {4'h0, an}, {4'h0, a});
    check({tag, "_seg"}, seg, s);
  endtask

  initial begin
    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    rst    = 1'b1;
    en     = 4'b1111;
    bin    = 16'h129d;
    dpin   = 4'b1000;
    blink  = 4'b0000;
    lzb    = 1'b0;
    bright = 2'd3;
    model_clear();
    #1;
    expect_out("reset", 4'b1111, 8'hFF);
    check("reset_fs", {7'h0, frame_start}, 8'h00);
    @(posedge clk_1kHz);
    @(negedge clk_1kHz);
    rst = 1'b0;

    // Basic scan and decode
    run(2);
    expect_out("scan_d0", 4'b1110, 8'hA1);
    check("scan_fs0", {7'h0, frame_start}, 8'h01);
    run(4);
    expect_out("scan_d1", 4'b1101, 8'h90);
    run(4);
    expect_out("scan_d2", 4'b1011, 8'hA4);
    run(4);
    expect_out("scan_d3", 4'b0111, 8'h79);
    run(4);
    check("scan_fs16", {7'h0, frame_start}, 8'h01);

    // Snapshot: change bin while digit 1 is shown
    run(4);
    bin = 16'h0000;
    run(4);
    expect_out("snap_d2", 4'b1011, 8'hA4);
    run(4);
    expect_out("snap_d3", 4'b0111, 8'h79);
    run(4);
    expect_out("snap_next_d0", 4'b1110, 8'hC0);

    // Leading-zero blanking
    bin  = 16'h0070;
    lzb  = 1'b1;
    dpin = 4'b0100;
    run(16);
    expect_out("lzb_d0", 4'b1110, 8'hC0);
    run(4);
    expect_out("lzb_d1", 4'b1101, 8'hF8);
    run(4);
    expect_out("lzb_d2", 4'b1011, 8'h7F);
    run(4);
    expect_out("lzb_d3", 4'b1111, 8'hFF);
    lzb = 1'b0;
    run(16);
    expect_out("nolzb_d3", 4'b0111, 8'hC0);

    // PWM, blink, enable
    bright = 2'd1;
    run(32);
    blink = 4'b0001;
    run(48);
    en = 4'b0101;
    run(32);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    expect_out("async_rst", 4'b1111, 8'hFF);
    check("async_rst_fs", {7'h0, frame_start}, 8'h00);
    @(posedge clk_1kHz);
    @(negedge clk_1kHz);
    rst = 1'b0;
    model_clear();
    run(2);
    check("restart_d0_an", {4'h0, an}, 8'h0E);
    run(30);

    // Randomized: inputs change at random points, including mid-frame
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        en     = 4'($urandom);
        dpin   = 4'($urandom);
        blink  = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
        lzb    = 1'($urandom);
        bright = 2'($urandom);
        // Bias toward values with leading zeros
        bin    = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
